// File: rtl/time_uart_tx_pkg.sv
// Shared definitions for the time-of-day UART transmitter: ASCII constants,
// message length, sequencer state encoding and the BCD digit formatter.
package time_uart_tx_pkg;

    localparam int unsigned MSG_LEN = 13;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // One BCD nibble to its ASCII digit; non-decimal nibbles print as '?'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return ASCII_ZERO + {4'd0, nib};
        end
        return ASCII_QMARK;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, each bit held BAUD_DIV cycles.
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   DATA      byte to send, captured when LOAD and READY are both high
//   LOAD      request to start a frame with DATA
//   READY     high when idle or in the last cycle of the stop bit
//   TXD       serial line, idle high (registered)
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       LOAD,
    output logic       READY,
    output logic       TXD
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_D7    = 4'd8;
    localparam logic [3:0]  BIT_STOP  = 4'd9;

    logic        active_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_q;
    logic [7:0]  sh_q;
    logic        txd_q;
    logic        bit_end_c;

    // Bit index 0 is the start bit, 1..8 data bits, 9 the stop bit.
    always_comb begin
        bit_end_c = active_q && (baud_q == BAUD_LAST);
        READY     = !active_q || (bit_end_c && (bit_q == BIT_STOP));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            txd_q    <= 1'b1;
        end else if (LOAD && READY) begin
            // Loading in the last stop-bit cycle chains frames with no gap.
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= DATA;
            txd_q    <= 1'b0;
        end else if (bit_end_c) begin
            baud_q <= '0;
            if (bit_q == BIT_STOP) begin
                active_q <= 1'b0;
                bit_q    <= '0;
                txd_q    <= 1'b1;
            end else begin
                bit_q <= bit_q + 4'd1;
                if (bit_q == BIT_D7) begin
                    txd_q <= 1'b1;
                end else begin
                    txd_q <= sh_q[0];
                    sh_q  <= {1'b0, sh_q[7:1]};
                end
            end
        end else if (active_q) begin
            baud_q <= baud_q + 16'd1;
        end
    end

    assign TXD = txd_q;

endmodule

// File: rtl/time_uart_tx.sv
// Snapshots the BCD time word on SEND and transmits "HH:MM:SS.mm\r\n"
// over an 8N1 UART line.
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   TIME      {HH, MM, ss, mm}, two BCD digits per byte
//   SEND      single-cycle transmit request, ignored while BUSY
//   TXD       serial output, idle high
//   BUSY      high while a message is in progress
//   DONE      one-cycle pulse after the final stop bit
module time_uart_tx
    import time_uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] TIME,
    input  logic        SEND,
    output logic        TXD,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [3:0] IDX_LAST = 4'(MSG_LEN - 1);

    state_t      state_q;
    logic [31:0] snap_q;
    logic [3:0]  idx_q;
    logic        busy_q;
    logic        done_q;

    logic        accept_c;
    logic [3:0]  idx_next_c;
    logic        ser_load_c;
    logic [7:0]  ser_data_c;
    logic        ser_ready;

    // Character idx of the message for time word w.
    function automatic logic [7:0] char_at(input logic [31:0] w, input logic [3:0] idx);
        case (idx)
            4'd0:    return bcd_to_ascii(w[31:28]);
            4'd1:    return bcd_to_ascii(w[27:24]);
            4'd2:    return ASCII_COLON;
            4'd3:    return bcd_to_ascii(w[23:20]);
            4'd4:    return bcd_to_ascii(w[19:16]);
            4'd5:    return ASCII_COLON;
            4'd6:    return bcd_to_ascii(w[15:12]);
            4'd7:    return bcd_to_ascii(w[11:8]);
            4'd8:    return ASCII_DOT;
            4'd9:    return bcd_to_ascii(w[7:4]);
            4'd10:   return bcd_to_ascii(w[3:0]);
            4'd11:   return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    // Serializer handoff: the first char is formatted straight from TIME on
    // the accepting edge; later chars are loaded in the last stop-bit cycle.
    always_comb begin
        accept_c   = SEND && !busy_q;
        idx_next_c = idx_q + 4'd1;
        ser_load_c = accept_c ||
                     ((state_q == ST_SHIFT) && ser_ready && (idx_q != IDX_LAST));
        ser_data_c = accept_c ? char_at(TIME, 4'd0) : char_at(snap_q, idx_next_c);
    end

    // Sequencer: LOAD marks the cycle after a char was handed over.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (accept_c) begin
                        snap_q  <= TIME;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (idx_q != IDX_LAST) begin
                            idx_q   <= idx_next_c;
                            state_q <= ST_LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .CLK  (CLK),
        .RST  (RST),
        .DATA (ser_data_c),
        .LOAD (ser_load_c),
        .READY(ser_ready),
        .TXD  (TXD)
    );

    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
